dmem_responder: RTL and testbench

- Data-memory slave that answers load/store requests issued by the pipeline's Memory stage over a valid/ready request–response handshake.
- Holds DEPTH_WORDS 32-bit little-endian words.
- Supports byte, halfword and word accesses with sign or zero extension on loads, a configurable number of wait states, and error responses for misaligned or out-of-range addresses.
- Sits between the Memory stage and the Writeback path; replaces the zero-latency data RAM once stall support exists.

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the Memory stage: byte/half/word loads and stores
// over a valid/ready request/response handshake, with configurable wait states
// and error responses for misaligned, out-of-range or reserved-size accesses.

// One byte lane of the data memory: write at the clock edge, asynchronous read.
module dmem_lane #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH_WORDS];

  // Commit the lane write; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int NUM_LANES = 4;
  localparam int AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t state;
  logic [3:0] waitCnt;
  req_t reqQ, reqIn, cur;

  logic doAccess, accErr;
  logic [AW-1:0] idx;
  logic [NUM_LANES-1:0] laneSel, laneWe;
  logic [NUM_LANES-1:0][7:0] laneWdata, laneRdata;
  logic [31:0] rdWord, loadData, rspData;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign reqIn = '{we: req_we, size: req_size, uns: req_unsigned,
                   addr: req_addr, wdata: req_wdata};

  // With no wait states the access happens on the acceptance edge itself, so
  // it must use the live request rather than the not-yet-latched copy.
  assign cur = (WAIT_CYCLES == 0) ? reqIn : reqQ;

  // Reset has priority so a transaction caught in WAIT never writes memory.
  assign doAccess = !rst && ((WAIT_CYCLES == 0) ? (state == S_IDLE && req_valid)
                                                : (state == S_WAIT && waitCnt == 4'd0));

  assign idx = cur.addr[AW+1:2];

  // Error classification, lane selection and store data replication.
  always_comb begin
    accErr = (cur.size == 2'b11)
          || (cur.size == 2'b01 && cur.addr[0])
          || (cur.size == 2'b10 && cur.addr[1:0] != 2'b00)
          || (cur.addr[31:2] >= 30'(DEPTH_WORDS));
    laneSel   = '0;
    laneWdata = cur.wdata;
    case (cur.size)
      2'b00: begin
        laneSel[cur.addr[1:0]] = 1'b1;
        laneWdata = {4{cur.wdata[7:0]}};
      end
      2'b01: begin
        laneSel   = cur.addr[1] ? 4'b1100 : 4'b0011;
        laneWdata = {2{cur.wdata[15:0]}};
      end
      2'b10:   laneSel = 4'b1111;
      default: laneSel = '0;
    endcase
    laneWe = (doAccess && cur.we && !accErr) ? laneSel : '0;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dmem_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (laneWe[l]),
      .idx   (idx),
      .wdata (laneWdata[l]),
      .rdata (laneRdata[l])
    );
  end

  // Load extraction: pick the addressed byte/half, then sign- or zero-extend.
  always_comb begin
    rdWord  = laneRdata;
    byteSel = laneRdata[cur.addr[1:0]];
    halfSel = cur.addr[1] ? rdWord[31:16] : rdWord[15:0];
    case (cur.size)
      2'b00:   loadData = cur.uns ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
      2'b01:   loadData = cur.uns ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: loadData = rdWord;
    endcase
    rspData = (accErr || cur.we) ? 32'b0 : loadData;
  end

  // Handshake FSM with registered outputs; response fields freeze in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      waitCnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          reqQ      <= reqIn;
          req_ready <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rspData;
            rsp_err   <= accErr;
          end else begin
            state   <= S_WAIT;
            waitCnt <= 4'(WAIT_CYCLES - 1);
          end
        end
        S_WAIT: if (waitCnt == 4'd0) begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= rspData;
          rsp_err   <= accErr;
        end else begin
          waitCnt <= waitCnt - 4'd1;
        end
        S_RESP: if (rsp_ready) begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded random + directed bench for dmem_responder. Instance 0 has one
// wait state, instance 1 has none; both are checked by the same monitor
// against a byte-array reference model of the memory.
module tb_dmem_responder;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] reqValid, reqReady, reqWe, reqUns, rspValid, rspReady, rspErr;
  logic [1:0][1:0]  reqSize;
  logic [1:0][31:0] reqAddr, reqWdata, rspRdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_we(reqWe[0]), .req_size(reqSize[0]), .req_unsigned(reqUns[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .rsp_valid(rspValid[0]),
    .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_we(reqWe[1]), .req_size(reqSize[1]), .req_unsigned(reqUns[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .rsp_valid(rspValid[1]),
    .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1]));

  int nVec = 0;
  int nErr = 0;
  int cyc  = 0;
  int rspMode = 0;  // 0: rsp_ready high, 1: random, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] mdl [2][1024];

  // Cycles from the acceptance cycle to the first cycle showing rsp_valid.
  function automatic int lat(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the access rules, at byte granularity.
  task automatic refAccess(input int d, input bit we, input logic [1:0] size,
                           input bit uns, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output logic [31:0] rd, output logic err);
    int n;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || ((addr % n) != 0) || (addr >= 32'(4 * DEPTH));
    rd  = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mdl[d][addr + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = mdl[d][addr + i];
      if (!uns && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
    end
  endtask

  // Drive a request until accepted; optionally score its response.
  task automatic issue(input int d, input bit we, input logic [1:0] size,
                       input bit uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit expRsp,
                       input string name);
    logic [31:0] rd;
    logic err;
    int guard;
    guard = 0;
    @(posedge clk); #1;
    reqValid[d] = 1'b1; reqWe[d] = we; reqSize[d] = size; reqUns[d] = uns;
    reqAddr[d]  = addr; reqWdata[d] = wdata;
    while (!reqReady[d]) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 60) begin
        nVec++; nErr++;
        $display("FAIL %s: request not accepted within 60 cycles", name);
        reqValid[d] = 1'b0;
        return;
      end
    end
    if (expRsp) begin
      refAccess(d, we, size, uns, addr, wdata, rd, err);
      sbq.push_back('{d, rd, err, cyc, name});
    end
    @(posedge clk); #1;
    // Scramble the request lines so a responder that re-samples them is caught.
    reqValid[d] = 1'b0; reqWe[d] = 1'($urandom); reqSize[d] = 2'($urandom);
    reqUns[d] = 1'($urandom); reqAddr[d] = $urandom; reqWdata[d] = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() > 0) begin
      @(posedge clk);
      guard++;
      if (guard > 300) begin
        nVec++; nErr++;
        $display("FAIL drain: %0d responses never arrived", sbq.size());
        sbq.delete();
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic checkResetOutputs(string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_req_ready"}, 32'(reqReady[d]), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rspValid[d]), 32'd0);
      check({tag, "_rsp_rdata"}, rspRdata[d], 32'd0);
      check({tag, "_rsp_err"},   32'(rspErr[d]), 32'd0);
    end
  endtask

  task automatic randomTraffic(input int d, input int count);
    logic [31:0] addr;
    logic [1:0]  size;
    int r, s;
    for (int w = 0; w < 4; w++) begin
      issue(d, 1'b1, 2'd2, 1'b0, 32'h3F0 + 32'(4*w), $urandom, 1'b1, "init_hi");
      issue(d, 1'b1, 2'd2, 1'b0, 32'(4*w), $urandom, 1'b1, "init_lo");
    end
    rspMode = 1;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 15);
      if (r < 7)       addr = 32'h3F0 + 32'($urandom_range(0, 15));
      else if (r < 14) addr = 32'($urandom_range(0, 15));
      else if (r == 14) addr = 32'h400 + 32'($urandom_range(0, 15));
      else addr = (32'd1 << (16 + $urandom_range(0, 15))) | 32'h3F0;
      s = $urandom_range(0, 6);
      size = (s == 6) ? 2'd3 : 2'(s % 3);
      issue(d, 1'($urandom), size, 1'($urandom), addr, $urandom, 1'b1, "random");
    end
    drain();
    rspMode = 0;
  endtask

  // rsp_ready driver.
  initial begin
    rspReady = '1;
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
        rspReady[d] = (rspMode == 0) ? 1'b1 : (rspMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: protocol checks and scoreboard comparison at the falling edge.
  logic [1:0] busy = '0, prevValid = '0, prevReady = '0, prevErr = '0;
  logic [1:0][31:0] prevRdata;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy = '0; prevValid = '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        check("req_ready", 32'(reqReady[d]), 32'(!busy[d]));
        if (prevValid[d] && !prevReady[d]) begin
          check("rsp_hold_valid", 32'(rspValid[d]), 32'd1);
          check("rsp_hold_rdata", rspRdata[d], prevRdata[d]);
          check("rsp_hold_err",   32'(rspErr[d]), 32'(prevErr[d]));
        end
        if (rspValid[d] && !prevValid[d]) begin
          if (sbq.size() == 0 || sbq[0].d != d)
            check("unexpected_rsp", 32'(rspValid[d]), 32'd0);
          else
            check({sbq[0].name, "_latency"}, 32'(cyc - sbq[0].acc), 32'(lat(d)));
        end
        if (rspValid[d] && rspReady[d]) begin
          if (sbq.size() > 0 && sbq[0].d == d) begin
            e = sbq.pop_front();
            check({e.name, "_rdata"}, rspRdata[d], e.rdata);
            check({e.name, "_err"},   32'(rspErr[d]), 32'(e.err));
          end
          busy[d] = 1'b0;
        end
        if (reqValid[d] && reqReady[d]) busy[d] = 1'b1;
        prevValid[d] = rspValid[d];
        prevReady[d] = rspReady[d];
        prevRdata[d] = rspRdata[d];
        prevErr[d]   = rspErr[d];
      end
    end
  end

  initial begin
    rst = 1'b1;
    reqValid = '0; reqWe = '0; reqSize = '0; reqUns = '0; reqAddr = '0; reqWdata = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("reset");

    // Word stores at the top of memory, read back.
    issue(0, 1, 2'd2, 0, 32'h3FC, 32'h0000_0777, 1, "sw_3fc");
    issue(0, 1, 2'd2, 0, 32'h3F8, 32'h0005_4321, 1, "sw_3f8");
    issue(0, 0, 2'd2, 0, 32'h3FC, 32'h0, 1, "lw_3fc");
    issue(0, 0, 2'd2, 0, 32'h3F8, 32'h0, 1, "lw_3f8");

    // Sub-word store and extending loads.
    issue(0, 1, 2'd0, 0, 32'h3F9, 32'h0000_00AB, 1, "sb_3f9");
    issue(0, 0, 2'd2, 0, 32'h3F8, 32'h0, 1, "lw_after_sb");
    issue(0, 0, 2'd0, 0, 32'h3F9, 32'h0, 1, "lb_3f9");
    issue(0, 0, 2'd0, 1, 32'h3F9, 32'h0, 1, "lbu_3f9");
    issue(0, 0, 2'd1, 0, 32'h3F8, 32'h0, 1, "lh_3f8");
    issue(0, 0, 2'd1, 1, 32'h3FA, 32'h0, 1, "lhu_3fa");

    // Error responses leave memory untouched.
    issue(0, 0, 2'd2, 0, 32'h3FA, 32'h0, 1, "lw_misaligned");
    issue(0, 1, 2'd1, 0, 32'h3F9, 32'hFFFF_FFFF, 1, "sh_misaligned");
    issue(0, 1, 2'd2, 0, 32'h400, 32'hFFFF_FFFF, 1, "sw_oor");
    issue(0, 1, 2'd3, 0, 32'h3F8, 32'hFFFF_FFFF, 1, "reserved_size");
    issue(0, 1, 2'd2, 0, 32'h8000_03F8, 32'hFFFF_FFFF, 1, "sw_no_alias");
    issue(0, 0, 2'd2, 0, 32'h3F8, 32'h0, 1, "lw_after_err");
    drain();

    // Back-pressure: response held while a new request waits.
    rspMode = 2;
    issue(0, 0, 2'd2, 0, 32'h3FC, 32'h0, 1, "lw_stalled");
    fork
      issue(0, 0, 2'd0, 1, 32'h3FC, 32'h0, 1, "lbu_queued");
      begin repeat (5) @(posedge clk); rspMode = 0; end
    join
    drain();

    // Reset while in WAIT drops the store.
    issue(0, 1, 2'd2, 0, 32'h3FC, 32'h1234_5678, 0, "sw_reset_dropped");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("wait_reset");
    issue(0, 0, 2'd2, 0, 32'h3FC, 32'h0, 1, "lw_after_reset");
    drain();

    randomTraffic(0, 150);

    // Zero-wait-state instance.
    issue(1, 1, 2'd2, 0, 32'h000, 32'hDEAD_BEEF, 1, "sw0_000");
    issue(1, 0, 2'd2, 0, 32'h000, 32'h0, 1, "lw0_000");
    drain();
    randomTraffic(1, 120);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
